// File: rtl/cp0_exc_unit.sv
// MIPS coprocessor-0: Status/Cause/EPC/PRId, interrupt qualification and exception capture.
// Optional Count/Compare timer (regs 9/11, timer_irq) is built when CP0_TIMER_EN is defined.
module cp0_exc_unit #(
    parameter int          N_HWINT    = 6,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0007,
    parameter logic [31:0] KTEXT_BASE = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic               we,
    input  logic [4:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [29:0]        pc,
    input  logic               in_bd,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic [N_HWINT-1:0] hw_int,
    input  logic               eret,
    output logic               exc_take,
    output logic               int_req,
    output logic [29:0]        epc_out,
    output logic               timer_irq
);

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;

    logic [N_HWINT-1:0] r_im;
    logic [N_HWINT-1:0] r_ip;
    logic               r_exl;
    logic               r_ie;
    logic               r_bd;
    logic [4:0]         r_exccode;
    logic [29:0]        r_epc;

    logic [N_HWINT-1:0] w_irq_vec;
    logic               w_timer_irq;
    logic               w_wr_ok;
    logic [4:0]         w_sel_code;
    logic               w_epc_upd;
    logic [29:0]        w_epc_cand;
    logic [31:0]        w_status;
    logic [31:0]        w_cause;

    always_comb begin
        w_irq_vec            = hw_int;
        w_irq_vec[N_HWINT-1] = hw_int[N_HWINT-1] | w_timer_irq;
    end

    assign int_req    = (|(w_irq_vec & r_im)) & r_ie & ~r_exl;
    assign exc_take   = int_req | exc_req;
    assign w_sel_code = int_req ? 5'd0 : exc_code;
    // A take always wins, so any mtc0 landing on the same edge is dropped.
    assign w_wr_ok    = we & ~exc_take;
    assign w_epc_upd  = ~r_exl & ({pc, 2'b00} < KTEXT_BASE);
    assign w_epc_cand = in_bd ? (pc - 30'd1) : pc;
    assign epc_out    = (we && wr_addr == A_EPC) ? wr_data[31:2] : r_epc;
    assign timer_irq  = w_timer_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_im      <= '0;
            r_ip      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_exccode <= 5'd0;
            r_epc     <= 30'd0;
        end else begin
            r_ip <= w_irq_vec;
            if (exc_take) begin
                r_exl     <= 1'b1;
                r_exccode <= w_sel_code;
                if (w_epc_upd) begin
                    r_epc <= w_epc_cand;
                    r_bd  <= in_bd;
                end
            end else begin
                if (w_wr_ok && wr_addr == A_STATUS) begin
                    r_im  <= wr_data[10 +: N_HWINT];
                    r_exl <= wr_data[1];
                    r_ie  <= wr_data[0];
                end
                if (w_wr_ok && wr_addr == A_EPC) begin
                    r_epc <= wr_data[31:2];
                end
                // eret after the Status write so the written EXL is overridden.
                if (eret) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_timer_irq <= 1'b0;
        end else begin
            if (w_wr_ok && wr_addr == A_COUNT) begin
                r_count <= wr_data;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr_ok && wr_addr == A_COMPARE) begin
                r_compare   <= wr_data;
                r_timer_irq <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'd0) begin
                r_timer_irq <= 1'b1;
            end
        end
    end

    assign w_timer_irq = r_timer_irq;
`else
    assign w_timer_irq = 1'b0;
`endif

    always_comb begin
        w_status               = '0;
        w_status[10 +: N_HWINT] = r_im;
        w_status[1]            = r_exl;
        w_status[0]            = r_ie;
    end

    always_comb begin
        w_cause                = '0;
        w_cause[31]            = r_bd;
        w_cause[10 +: N_HWINT] = r_ip;
        w_cause[6:2]           = r_exccode;
    end

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            A_STATUS: rd_data = w_status;
            A_CAUSE:  rd_data = w_cause;
            A_EPC:    rd_data = {r_epc, 2'b00};
            A_PRID:   rd_data = PRID_VAL;
`ifdef CP0_TIMER_EN
            A_COUNT:   rd_data = r_count;
            A_COMPARE: rd_data = r_compare;
`endif
            default:  rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [29:0] pc;
    logic        in_bd;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        exc_take;
    logic        int_req;
    logic [29:0] epc_out;
    logic        timer_irq;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .pc(pc), .in_bd(in_bd),
        .exc_req(exc_req), .exc_code(exc_code), .hw_int(hw_int), .eret(eret),
        .exc_take(exc_take), .int_req(int_req), .epc_out(epc_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input int k, input logic [31:0] e, input string n);
        exp_t x;
        x.kind = k;
        x.exp  = e;
        x.name = n;
        q.push_back(x);
    endtask

    task automatic rdc(input logic [4:0] a, input logic [31:0] e, input string n);
        rd_addr = a;
        push(0, e, n);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        we      = 1'b0;
        exc_req = 1'b0;
        eret    = 1'b0;
        in_bd   = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = rd_data;
                1:       act = {31'd0, exc_take};
                2:       act = {2'd0, epc_out};
                3:       act = {31'd0, int_req};
                default: act = {31'd0, timer_irq};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end else begin
                $display("ok   %s: %h", e.name, act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rd_addr = 5'd0; we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        pc = 30'd0; in_bd = 1'b0; exc_req = 1'b0; exc_code = 5'd0; hw_int = 6'd0; eret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        rdc(12, 32'h0, "rst_status"); push(1, 0, "rst_take"); push(3, 0, "rst_intreq"); push(4, 0, "rst_timer");
        cyc(); rdc(13, 32'h0, "rst_cause");
        cyc(); rdc(14, 32'h0, "rst_epc");
        cyc(); rdc(15, 32'h7, "rst_prid");
        cyc();

        pc = 30'h0000_0C10; we = 1'b1; wr_addr = 12; wr_data = 32'h0000_0401;
        cyc(); hw_int = 6'b000001; push(1, 1, "t2_take"); push(3, 1, "t2_intreq");
        cyc(); rdc(12, 32'h0000_0403, "t2_status"); push(1, 0, "t2_exl_masks");
        cyc(); rdc(13, 32'h0000_0400, "t2_cause");
        cyc(); rdc(14, 32'h0000_3040, "t2_epc"); push(2, 32'h0000_0C10, "t2_epc_out");
        cyc();

        hw_int = 6'd0; eret = 1'b1;
        cyc(); rdc(12, 32'h0000_0401, "eret_exl_clr");
        cyc(); exc_req = 1'b1; exc_code = 5'd4; in_bd = 1'b1; pc = 30'h0000_0C11; push(1, 1, "t3_take");
        cyc(); rdc(13, 32'h8000_0010, "t3_cause");
        cyc(); rdc(14, 32'h0000_3040, "t3_epc");
        cyc();

        exc_req = 1'b1; exc_code = 5'd10; pc = 30'h0000_0100;
        cyc(); rdc(13, 32'h8000_0028, "t4_nested_cause");
        cyc(); rdc(14, 32'h0000_3040, "t4_nested_epc");
        cyc();

        eret = 1'b1;
        cyc(); exc_req = 1'b1; exc_code = 5'd2; pc = 30'h0000_1060;
        cyc(); rdc(13, 32'h8000_0008, "t4_ktext_cause");
        cyc(); rdc(14, 32'h0000_3040, "t4_ktext_epc");
        cyc();

        eret = 1'b1;
        cyc(); hw_int = 6'b000001; exc_req = 1'b1; exc_code = 5'd12; pc = 30'h0000_0020; push(1, 1, "t4_both_take");
        cyc(); rdc(13, 32'h0000_0400, "t4_both_cause");
        cyc(); rdc(14, 32'h0000_0080, "t4_both_epc");
        cyc();

        hw_int = 6'd0; eret = 1'b1;
        cyc(); exc_req = 1'b1; exc_code = 5'd3; pc = 30'h0000_0030;
        we = 1'b1; wr_addr = 12; wr_data = 32'h0000_FC00;
        cyc(); rdc(12, 32'h0000_0403, "t4_wr_lost");
        cyc(); rdc(13, 32'h0000_000C, "t4_wr_lost_cause");
        cyc(); rdc(14, 32'h0000_00C0, "t4_wr_lost_epc");
        cyc();

        we = 1'b1; wr_addr = 14; wr_data = 32'h0000_1234; push(2, 32'h0000_048D, "t5_fwd");
        cyc(); rdc(14, 32'h0000_1234, "t5_epc_rd"); push(2, 32'h0000_048D, "t5_epc_reg");
        cyc(); we = 1'b1; wr_addr = 12; wr_data = 32'h0000_0803; eret = 1'b1;
        cyc(); rdc(12, 32'h0000_0801, "t5_eret_after_wr");
        cyc(); hw_int = 6'b000010; push(3, 1, "t5_irq11_req"); push(1, 1, "t5_irq11_take");
        cyc(); hw_int = 6'd0; rdc(12, 32'h0000_0803, "t5_irq11_exl");
        cyc();

        we = 1'b1; wr_addr = 13; wr_data = 32'hFFFF_FFFF;
        cyc(); rdc(13, 32'h0, "cause_ro");
        cyc(); we = 1'b1; wr_addr = 15; wr_data = 32'h0;
        cyc(); rdc(15, 32'h7, "prid_ro");
        cyc(); we = 1'b1; wr_addr = 20; wr_data = 32'hFFFF_FFFF;
        cyc(); rdc(20, 32'h0, "unmapped_rd");
        cyc();
`ifndef CP0_TIMER_EN
        we = 1'b1; wr_addr = 9; wr_data = 32'h5;
        cyc(); rdc(9, 32'h0, "no_timer_count");
        cyc(); rdc(11, 32'h0, "no_timer_compare"); push(4, 0, "no_timer_irq");
        cyc();
`endif

        rst = 1'b1; rdc(12, 32'h0, "t1_async_status"); push(1, 0, "t1_take");
        cyc(); rdc(14, 32'h0, "t1_epc");
        cyc(); rst = 1'b0; rdc(15, 32'h7, "t1_prid");
        cyc();

        exc_req = 1'b1; exc_code = 5'd1; pc = 30'd0; in_bd = 1'b1;
        cyc(); rdc(14, 32'hFFFF_FFFC, "wrap_epc");
        cyc(); rdc(13, 32'h8000_0004, "wrap_cause");
        cyc();

`ifdef CP0_TIMER_EN
        eret = 1'b1;
        cyc(); we = 1'b1; wr_addr = 11; wr_data = 32'd5;
        cyc(); we = 1'b1; wr_addr = 9; wr_data = 32'd0;
        cyc();
        for (int i = 0; i < 6; i++) begin
            push(4, 0, "t6_irq_low");
            cyc();
        end
        push(4, 1, "t6_irq_rise");
        we = 1'b1; wr_addr = 12; wr_data = 32'h0000_8001;
        cyc(); push(1, 1, "t6_take");
        cyc(); we = 1'b1; wr_addr = 11; wr_data = 32'd0;
        cyc(); push(4, 0, "t6_clear");
        cyc();
`endif

        @(negedge clk);
        #1;
        rd_addr = 5'd15;
        #1;
        checks++;
        if (rd_data !== 32'h0000_0007) begin
            failures++;
            $display("FAIL final_prid: got %h expected %h", rd_data, 32'h0000_0007);
        end else begin
            $display("ok   final_prid: %h", rd_data);
        end
        checks++;
        if (exc_take !== 1'b0) begin
            failures++;
            $display("FAIL final_no_take: got %b expected 0", exc_take);
        end else begin
            $display("ok   final_no_take: %b", exc_take);
        end
        if (failures == 0 && checks >= 12) begin
            $display("PASS all checks");
        end else begin
            $display("FAIL summary: checks=%0d failures=%0d", checks, failures);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
